// File: rtl/octo_pkg.sv
// rtl/octo_pkg.sv - shared widths, entry type and clog2 helper for the octo result path
package octo_pkg;

    localparam int OCTO_RES_W   = 4;
    localparam int OCTO_TAG_W   = 16;
    localparam int OCTO_ENTRY_W = OCTO_TAG_W + OCTO_RES_W;

    typedef logic [OCTO_ENTRY_W-1:0] octo_entry_t;

    function automatic int octo_clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/octo_res_fifo.sv
// rtl/octo_res_fifo.sv - single-clock first-word-fall-through FIFO for one cluster channel
module octo_res_fifo
    import octo_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = OCTO_ENTRY_W
) (
    input  logic                         clk_octo,
    input  logic                         rst_octo,
    input  logic                         push,
    input  logic [DW-1:0]                din,
    input  logic                         pop,
    output logic [DW-1:0]                head,
    output logic [octo_clog2(DEPTH):0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int AW = octo_clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [DW-1:0] mem_q [DEPTH];

    // Pointer and occupancy update; the caller never pushes a full FIFO without popping it
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    // Control state; storage contents are don't-care after reset
    always_ff @(posedge clk_octo or posedge rst_octo) begin
        if (rst_octo) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage write
    always_ff @(posedge clk_octo) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

endmodule

// File: rtl/octo_res_merger.sv
// rtl/octo_res_merger.sv - per-cluster FIFOs, round-robin merge, registered output; stats under OCTO_RES_MERGER_STATS_EN
module octo_res_merger
    import octo_pkg::*;
#(
    parameter int NUM_VPE    = 4,
    parameter int RES_W      = OCTO_RES_W,
    parameter int TAG_W      = OCTO_TAG_W,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 32
) (
    input  logic                                              clk_octo,
    input  logic                                              rst_octo,
    input  logic [NUM_VPE*RES_W-1:0]                          vpe_res,
    input  logic [NUM_VPE*TAG_W-1:0]                          vpe_tag,
    input  logic [NUM_VPE-1:0]                                vpe_res_valid,
    output logic [NUM_VPE-1:0]                                vpe_stall,
    output logic [TAG_W+RES_W-1:0]                            out_data,
    output logic [((NUM_VPE > 1) ? octo_clog2(NUM_VPE) : 1)-1:0] out_src,
    output logic                                              out_valid,
    input  logic                                              out_ready,
    output logic [NUM_VPE-1:0]                                drop_pulse,
    input  logic                                              stat_clr,
    output logic [NUM_VPE*CNT_W-1:0]                          stat_res_cnt,
    output logic [NUM_VPE*CNT_W-1:0]                          stat_drop_cnt
);

    localparam int EW    = TAG_W + RES_W;
    localparam int SRC_W = (NUM_VPE > 1) ? octo_clog2(NUM_VPE) : 1;
    localparam int CW    = octo_clog2(FIFO_DEPTH) + 1;

    logic [EW-1:0]      fifo_head [NUM_VPE];
    logic [CW-1:0]      fifo_cnt  [NUM_VPE];
    logic [NUM_VPE-1:0] fifo_full, fifo_empty, push_ok, pop_sel;

    logic               load, grant_found;
    logic [SRC_W-1:0]   grant_sel, scan_sel;

    logic               out_valid_q, out_valid_d;
    logic [EW-1:0]      out_data_q, out_data_d;
    logic [SRC_W-1:0]   out_src_q, out_src_d;
    logic [SRC_W-1:0]   ptr_q, ptr_d;
    logic [NUM_VPE-1:0] stall_q, stall_d;
    logic [NUM_VPE-1:0] drop_q, drop_d;

    for (genvar g = 0; g < NUM_VPE; g++) begin : g_ch
        octo_res_fifo #(
            .DEPTH (FIFO_DEPTH),
            .DW    (EW)
        ) u_fifo (
            .clk_octo (clk_octo),
            .rst_octo (rst_octo),
            .push     (push_ok[g]),
            .din      ({vpe_tag[g*TAG_W +: TAG_W], vpe_res[g*RES_W +: RES_W]}),
            .pop      (pop_sel[g]),
            .head     (fifo_head[g]),
            .count    (fifo_cnt[g]),
            .full     (fifo_full[g]),
            .empty    (fifo_empty[g])
        );
    end

    // Round-robin grant from ptr upward with wrap; output register reloads when empty or accepted
    always_comb begin
        load        = !out_valid_q || out_ready;
        grant_found = 1'b0;
        grant_sel   = '0;
        scan_sel    = '0;
        for (int k = 0; k < NUM_VPE; k++) begin
            scan_sel = SRC_W'((int'(ptr_q) + k) % NUM_VPE);
            if (!grant_found && !fifo_empty[scan_sel]) begin
                grant_found = 1'b1;
                grant_sel   = scan_sel;
            end
        end
        pop_sel     = '0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_valid_d = grant_found;
            if (grant_found) begin
                pop_sel[grant_sel] = 1'b1;
                out_data_d         = fifo_head[grant_sel];
                out_src_d          = grant_sel;
                ptr_d              = SRC_W'((int'(grant_sel) + 1) % NUM_VPE);
            end
        end
    end

    // Push acceptance, drop detection and almost-full stall from the post-edge occupancy
    always_comb begin
        int next_cnt;
        next_cnt = 0;
        push_ok  = '0;
        drop_d   = '0;
        stall_d  = '0;
        for (int i = 0; i < NUM_VPE; i++) begin
            push_ok[i] = vpe_res_valid[i] && (!fifo_full[i] || pop_sel[i]);
            drop_d[i]  = vpe_res_valid[i] && !push_ok[i];
            next_cnt   = int'(fifo_cnt[i]) + (push_ok[i] ? 1 : 0) - (pop_sel[i] ? 1 : 0);
            stall_d[i] = (next_cnt >= FIFO_DEPTH - 1);
        end
    end

    // Output stream, arbitration pointer, stall and drop registers
    always_ff @(posedge clk_octo or posedge rst_octo) begin
        if (rst_octo) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            ptr_q       <= '0;
            stall_q     <= '0;
            drop_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            ptr_q       <= ptr_d;
            stall_q     <= stall_d;
            drop_q      <= drop_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_src    = out_src_q;
    assign vpe_stall  = stall_q;
    assign drop_pulse = drop_q;

`ifdef OCTO_RES_MERGER_STATS_EN
    logic [NUM_VPE*CNT_W-1:0] res_cnt_q, res_cnt_d;
    logic [NUM_VPE*CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    // Saturating per-channel event counters; clear wins over a coincident event
    always_comb begin
        res_cnt_d  = res_cnt_q;
        drop_cnt_d = drop_cnt_q;
        for (int i = 0; i < NUM_VPE; i++) begin
            if (stat_clr) begin
                res_cnt_d[i*CNT_W +: CNT_W]  = '0;
                drop_cnt_d[i*CNT_W +: CNT_W] = '0;
            end else begin
                if (push_ok[i] && (res_cnt_q[i*CNT_W +: CNT_W] != '1)) begin
                    res_cnt_d[i*CNT_W +: CNT_W] = res_cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
                end
                if (drop_d[i] && (drop_cnt_q[i*CNT_W +: CNT_W] != '1)) begin
                    drop_cnt_d[i*CNT_W +: CNT_W] = drop_cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk_octo or posedge rst_octo) begin
        if (rst_octo) begin
            res_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            res_cnt_q  <= res_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign stat_res_cnt  = res_cnt_q;
    assign stat_drop_cnt = drop_cnt_q;
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
    assign stat_res_cnt    = '0;
    assign stat_drop_cnt   = '0;
`endif

endmodule

// File: tb/tb_octo_res_merger.sv
// tb/tb_octo_res_merger.sv - scoreboard bench for octo_res_merger with directed vectors
module tb_octo_res_merger;

    localparam int NUM_VPE    = 4;
    localparam int RES_W      = 4;
    localparam int TAG_W      = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = 32;
    localparam int EW         = TAG_W + RES_W;
    localparam int SRC_W      = 2;

    logic                       clk_octo;
    logic                       rst_octo;
    logic [NUM_VPE*RES_W-1:0]   vpe_res;
    logic [NUM_VPE*TAG_W-1:0]   vpe_tag;
    logic [NUM_VPE-1:0]         vpe_res_valid;
    logic [NUM_VPE-1:0]         vpe_stall;
    logic [EW-1:0]              out_data;
    logic [SRC_W-1:0]           out_src;
    logic                       out_valid;
    logic                       out_ready;
    logic [NUM_VPE-1:0]         drop_pulse;
    logic                       stat_clr;
    logic [NUM_VPE*CNT_W-1:0]   stat_res_cnt;
    logic [NUM_VPE*CNT_W-1:0]   stat_drop_cnt;

    octo_res_merger #(
        .NUM_VPE    (NUM_VPE),
        .RES_W      (RES_W),
        .TAG_W      (TAG_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_octo      (clk_octo),
        .rst_octo      (rst_octo),
        .vpe_res       (vpe_res),
        .vpe_tag       (vpe_tag),
        .vpe_res_valid (vpe_res_valid),
        .vpe_stall     (vpe_stall),
        .out_data      (out_data),
        .out_src       (out_src),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .drop_pulse    (drop_pulse),
        .stat_clr      (stat_clr),
        .stat_res_cnt  (stat_res_cnt),
        .stat_drop_cnt (stat_drop_cnt)
    );

    initial clk_octo = 1'b0;
    always #5 clk_octo = ~clk_octo;

    typedef struct {
        logic [SRC_W-1:0] src;
        logic [EW-1:0]    data;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every accepted beat must match the head of the expected queue
    always @(negedge clk_octo) begin
        exp_t e;
        if (!rst_octo && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat actual src=%0d data=%0h required=no beat", out_src, out_data);
            end else begin
                e = sb_q.pop_front();
                chk("beat_src", 32'(out_src), 32'(e.src));
                chk("beat_data", 32'(out_data), 32'(e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk_octo);
        #1;
    endtask

    task automatic drive(input int ch, input logic [15:0] tag, input logic [3:0] res, input bit expect_beat);
        vpe_res_valid[ch]          = 1'b1;
        vpe_tag[ch*TAG_W +: TAG_W] = tag;
        vpe_res[ch*RES_W +: RES_W] = res;
        if (expect_beat) begin
            sb_q.push_back('{src: SRC_W'(ch), data: {tag, res}});
        end
    endtask

    task automatic do_reset();
        rst_octo      = 1'b1;
        vpe_res_valid = '0;
        out_ready     = 1'b0;
        stat_clr      = 1'b0;
        repeat (2) @(posedge clk_octo);
        sb_q.delete();
        #1;
        rst_octo = 1'b0;
        tick();
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        out_ready = 1'b1;
        while (sb_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(sb_q.size()), 32'd0);
        repeat (2) tick();
    endtask

    initial begin
        rst_octo      = 1'b1;
        vpe_res       = '0;
        vpe_tag       = '0;
        vpe_res_valid = '0;
        out_ready     = 1'b0;
        stat_clr      = 1'b0;
        repeat (2) @(posedge clk_octo);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_src", 32'(out_src), 32'd0);
        chk("rst_vpe_stall", 32'(vpe_stall), 32'd0);
        chk("rst_drop_pulse", 32'(drop_pulse), 32'd0);
        rst_octo = 1'b0;
        tick();

        // Single result: out_valid two cycles after the push
        out_ready = 1'b1;
        drive(2, 16'hBEEF, 4'h5, 1'b0);
        sb_q.push_back('{src: 2'd2, data: 20'hBEEF5});
        tick();
        vpe_res_valid = '0;
        chk("t1_valid_t1", 32'(out_valid), 32'd0);
        tick();
        chk("t1_valid_t2", 32'(out_valid), 32'd1);
        chk("t1_data", 32'(out_data), 32'h000BEEF5);
        chk("t1_src", 32'(out_src), 32'd2);
        tick();
        chk("t1_one_beat", 32'(out_valid), 32'd0);
        drain("t1_drained", 10);

        // Round-robin: simultaneous push on all channels
        do_reset();
        out_ready = 1'b1;
        drive(0, 16'hA000, 4'h1, 1'b1);
        drive(1, 16'hB111, 4'h2, 1'b1);
        drive(2, 16'hC222, 4'h3, 1'b1);
        drive(3, 16'hD333, 4'h4, 1'b1);
        tick();
        vpe_res_valid = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_valid", 32'(out_valid), 32'd1);
            chk("rr_src", 32'(out_src), 32'(k));
        end
        drain("rr_drained", 10);

        // Backpressure: held output stays stable
        do_reset();
        drive(0, 16'h1111, 4'h1, 1'b1);
        tick();
        drive(0, 16'h2222, 4'h2, 1'b1);
        tick();
        drive(0, 16'h3333, 4'h3, 1'b1);
        tick();
        vpe_res_valid = '0;
        for (int k = 0; k < 10; k++) begin
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_stable", 32'(out_data), 32'h00011111);
            tick();
        end
        drain("bp_drained", 20);

        // Overflow with the output register occupied
        do_reset();
        drive(0, 16'h0D0D, 4'hD, 1'b1);
        tick();
        vpe_res_valid = '0;
        tick();
        chk("ov_occupied", 32'(out_valid), 32'd1);
        for (int k = 1; k <= 6; k++) begin
            drive(1, 16'h4000 | 16'(k), 4'(k), (k <= 4));
            tick();
            vpe_res_valid = '0;
            if (k == 2) chk("ov_stall_k2", 32'(vpe_stall[1]), 32'd0);
            if (k == 3) chk("ov_stall_k3", 32'(vpe_stall[1]), 32'd1);
            chk("ov_drop", 32'(drop_pulse[1]), (k >= 5) ? 32'd1 : 32'd0);
        end
        tick();
        chk("ov_drop_end", 32'(drop_pulse[1]), 32'd0);
        drain("ov_drained", 20);

        // Push on a full FIFO in the cycle it pops
        do_reset();
        drive(1, 16'h0E0E, 4'hE, 1'b1);
        tick();
        vpe_res_valid = '0;
        tick();
        for (int k = 1; k <= 4; k++) begin
            drive(0, 16'h5000 | 16'(k), 4'(k), 1'b1);
            tick();
            vpe_res_valid = '0;
        end
        chk("fp_stall_full", 32'(vpe_stall[0]), 32'd1);
        out_ready = 1'b1;
        drive(0, 16'h5005, 4'h5, 1'b1);
        tick();
        vpe_res_valid = '0;
        chk("fp_no_drop", 32'(drop_pulse[0]), 32'd0);
        chk("fp_stall_kept", 32'(vpe_stall[0]), 32'd1);
        drain("fp_drained", 20);

        // Statistics: 5 accepted, 2 dropped on ch3, then clear coinciding with a push
        do_reset();
        for (int k = 1; k <= 7; k++) begin
            drive(3, 16'h6000 | 16'(k), 4'(k), (k <= 5));
            tick();
            vpe_res_valid = '0;
        end
        chk("st_drops_seen", 32'(drop_pulse[3]), 32'd1);
`ifdef OCTO_RES_MERGER_STATS_EN
        chk("st_res3", stat_res_cnt[3*CNT_W +: CNT_W], 32'd5);
        chk("st_drop3", stat_drop_cnt[3*CNT_W +: CNT_W], 32'd2);
        chk("st_res0", stat_res_cnt[0 +: CNT_W], 32'd0);
`endif
        stat_clr  = 1'b1;
        out_ready = 1'b1;
        drive(3, 16'h6008, 4'h8, 1'b1);
        tick();
        stat_clr      = 1'b0;
        vpe_res_valid = '0;
        chk("st_res3_clr", stat_res_cnt[3*CNT_W +: CNT_W], 32'd0);
        chk("st_drop3_clr", stat_drop_cnt[3*CNT_W +: CNT_W], 32'd0);
        drain("st_drained", 20);

        // Asynchronous reset mid-burst
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            drive(2, 16'h7000 | 16'(k), 4'(k), 1'b0);
            tick();
            vpe_res_valid = '0;
        end
        chk("ar_pre_valid", 32'(out_valid), 32'd1);
        chk("ar_pre_stall", 32'(vpe_stall[2]), 32'd1);
        #2;
        rst_octo = 1'b1;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_stall", 32'(vpe_stall), 32'd0);
        chk("ar_data", 32'(out_data), 32'd0);
        @(posedge clk_octo);
        #1;
        rst_octo  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("ar_no_output", 32'(out_valid), 32'd0);
        end

        chk("sb_empty_end", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
